// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit
//   Program counter + instruction register for the 16-bit CPU. Issues fetches
//   to a synchronous instruction memory of fixed read latency MEM_LAT (1..3)
//   and buffers one extra fetch request while a read is in flight.
// Ports:
//   clk, rst          clock (rising edge), asynchronous active-high reset
//   pc_clr            clear PC to PC_RESET, abort any fetch (highest priority)
//   pc_ic             PC increment (wraps modulo 2^ADDR_W)
//   pc_ld, pc_ld_val  PC load (jump support)
//   ir_ld             fetch request from the control unit
//   i_addr, i_rd      instruction-memory read address / one-cycle read strobe
//   i_rdata           instruction-memory read data
//   ir, ir_valid      instruction register and its valid flag
//   pc                current program counter
//   busy              a fetch is in flight
module instruction_fetch_unit #(
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 16,
  parameter int MEM_LAT  = 1,
  parameter int PC_RESET = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pc_clr,
  input  logic              pc_ic,
  input  logic              pc_ld,
  input  logic [ADDR_W-1:0] pc_ld_val,
  input  logic              ir_ld,
  output logic [ADDR_W-1:0] i_addr,
  output logic              i_rd,
  input  logic [DATA_W-1:0] i_rdata,
  output logic [DATA_W-1:0] ir,
  output logic              ir_valid,
  output logic [ADDR_W-1:0] pc,
  output logic              busy
);

  localparam logic [ADDR_W-1:0] PC_INIT  = ADDR_W'(PC_RESET);
  localparam logic [1:0]        LAT_INIT = 2'(MEM_LAT - 1);

  typedef enum logic {IDLE, READ} state_t;

  state_t            state;
  logic              pending;
  logic [1:0]        cnt;
  logic [ADDR_W-1:0] fetch_addr;

  // A fetch issues straight from IDLE in the request cycle so the memory sees
  // the address without an extra register stage.
  assign i_rd   = (state == IDLE) && (ir_ld || pending) && !pc_clr;
  assign i_addr = (state == READ) ? fetch_addr : pc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc         <= PC_INIT;
      ir         <= '0;
      ir_valid   <= 1'b0;
      busy       <= 1'b0;
      state      <= IDLE;
      pending    <= 1'b0;
      cnt        <= 2'd0;
      fetch_addr <= PC_INIT;
    end else begin
      if (pc_clr)     pc <= PC_INIT;
      else if (pc_ld) pc <= pc_ld_val;
      else if (pc_ic) pc <= pc + 1'b1;

      case (state)
        IDLE: begin
          if (pc_clr) begin
            pending <= 1'b0;
          end else if (ir_ld || pending) begin
            fetch_addr <= pc;           // pre-increment PC
            ir_valid   <= 1'b0;
            cnt        <= LAT_INIT;
            pending    <= 1'b0;
            busy       <= 1'b1;
            state      <= READ;
          end
        end
        READ: begin
          if (pc_clr) begin
            // abort: the in-flight data is dropped, ir_valid stays low
            pending <= 1'b0;
            busy    <= 1'b0;
            state   <= IDLE;
          end else begin
            if (ir_ld) pending <= 1'b1;  // one-deep; extra requests collapse
            if (cnt == 2'd0) begin
              ir       <= i_rdata;
              ir_valid <= 1'b1;
              busy     <= 1'b0;
              state    <= IDLE;
            end else begin
              cnt <= cnt - 2'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
